// File: rtl/fpu_scheduler_if.sv
// fpu_scheduler_if
//   Bundles the requester handshakes, the shared response bus and the fpu
//   connection of fpu_scheduler.
//   slave  : the scheduler side (drives readies, response, fpu operands/reset).
//   master : the environment side (requesters, response sinks and the fpu).
interface fpu_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_op_a;
    logic [31:0] req0_op_b;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_op_a;
    logic [31:0] req1_op_b;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_status;
    logic [31:0] fpu_op_a;
    logic [31:0] fpu_op_b;
    logic        fpu_rst_n;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;
    logic        busy;
    logic        grant_id;

    modport slave (
        input  req0_valid, req0_op_a, req0_op_b, rsp0_ready,
        input  req1_valid, req1_op_a, req1_op_b, rsp1_ready,
        input  fpu_data, fpu_status,
        output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        output rsp_data, rsp_status, fpu_op_a, fpu_op_b, fpu_rst_n,
        output busy, grant_id
    );

    modport master (
        output req0_valid, req0_op_a, req0_op_b, rsp0_ready,
        output req1_valid, req1_op_a, req1_op_b, rsp1_ready,
        output fpu_data, fpu_status,
        input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        input  rsp_data, rsp_status, fpu_op_a, fpu_op_b, fpu_rst_n,
        input  busy, grant_id
    );
endinterface

// File: rtl/fpu_scheduler.sv
// fpu_scheduler
//   Two-port round-robin scheduler sharing one fpu adder. A granted operand
//   pair is latched and driven to the fpu, the fpu is reset for one cycle so
//   it restarts its sequence, a fixed window is waited, and the captured
//   result/status is returned to the granted requester on valid/ready.
// Ports
//   clock100KHz : system clock
//   reset       : synchronous, active-low reset
//   bus         : fpu_scheduler_if.slave (requester 0/1 handshakes, shared
//                 rsp_data/rsp_status, fpu operands/reset/result, busy,
//                 grant_id)
module fpu_scheduler #(
    parameter int unsigned WAIT_CYCLES = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic           clock100KHz,
    input  logic           reset,
    fpu_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [1:0]       state;
    logic             rr_ptr;
    logic             grant;
    logic             fpu_rst_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [31:0]      data_q;
    logic [3:0]       status_q;

    logic             sel;
    logic             accept;
    logic             rsp_ready_sel;

    // rr_ptr only breaks ties; a lone requester is granted directly.
    always_comb begin
        sel           = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
        accept        = (state == IDLE) && reset && (bus.req0_valid || bus.req1_valid);
        rsp_ready_sel = grant ? bus.rsp1_ready : bus.rsp0_ready;
    end

    assign bus.req0_ready = accept && !sel;
    assign bus.req1_ready = accept && sel;
    assign bus.rsp0_valid = (state == RESP) && !grant;
    assign bus.rsp1_valid = (state == RESP) && grant;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_status = status_q;
    assign bus.fpu_op_a   = op_a;
    assign bus.fpu_op_b   = op_b;
    assign bus.fpu_rst_n  = fpu_rst_q;
    assign bus.busy       = (state != IDLE);
    assign bus.grant_id   = grant;

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            grant     <= 1'b0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            fpu_rst_q <= 1'b0;
            data_q    <= '0;
            status_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fpu_rst_q <= 1'b1;
                    if (accept) begin
                        op_a      <= sel ? bus.req1_op_a : bus.req0_op_a;
                        op_b      <= sel ? bus.req1_op_b : bus.req0_op_b;
                        grant     <= sel;
                        rr_ptr    <= !sel;
                        // Dropped on the accept edge so the fpu sits in reset
                        // for exactly the ISSUE cycle.
                        fpu_rst_q <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    fpu_rst_q <= 1'b1;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt == LAST) begin
                        data_q   <= bus.fpu_data;
                        status_q <= bus.fpu_status;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (rsp_ready_sel) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_scheduler.sv
// tb_fpu_scheduler
//   Self-checking bench for fpu_scheduler. A stand-in fpu returns a
//   deterministic result only in the exact cycle the scheduler should capture
//   it; a transaction-level model predicts grants, response timing and data.
`timescale 1ns/1ps
module tb_fpu_scheduler;
    localparam int unsigned W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    fpu_scheduler_if bus ();

    fpu_scheduler #(.WAIT_CYCLES(W), .CNT_W(7)) dut (
        .clock100KHz (clk),
        .reset       (rst_n),
        .bus         (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stand-in fpu behaviour: {data, status}.
    function automatic logic [35:0] fpu_ref(input logic [31:0] a, input logic [31:0] b);
        logic [5:0] e;
        if (a == b && a[24:0] == 25'h0) begin
            e = a[30:25];
            if (e == 6'd63) return {32'h0, 4'b0100};
            return {a[31], e + 6'd1, 25'h0, 4'b0001};
        end
        return {a + {b[15:0], b[31:16]}, 4'b0001 << (a[1:0] ^ b[1:0])};
    endfunction

    int unsigned fcnt = 0;
    always @(posedge clk) begin
        if (!bus.fpu_rst_n) fcnt <= 0;
        else if (fcnt < 100000) fcnt <= fcnt + 1;
    end

    logic [35:0] fpu_now;
    assign fpu_now        = fpu_ref(bus.fpu_op_a, bus.fpu_op_b);
    assign bus.fpu_data   = (fcnt == W - 1) ? fpu_now[35:4] : (32'hBAD0_0000 ^ fcnt);
    assign bus.fpu_status = (fcnt == W - 1) ? fpu_now[3:0] : 4'b1111;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level reference model, evaluated mid-cycle.
    bit grant_log[$];
    int n_resp = 0;

    initial begin : model
        bit          known, pend, owner, last, frst, w0, w1, g, resp_now, rdy;
        int unsigned acc;
        logic [31:0] ma, mb;
        logic [35:0] mexp;
        known = 0; pend = 0; owner = 0; last = 1; frst = 0; acc = 0;
        ma = '0; mb = '0; mexp = '0;
        forever begin
            @(negedge clk);
            w0 = (bus.req0_valid === 1'b1);
            w1 = (bus.req1_valid === 1'b1);
            g  = (w0 && w1) ? !last : w1;
            resp_now = pend && (cyc >= acc + 2 + W);
            if (known) begin
                chk("busy", bus.busy, pend);
                chk("req0_ready", bus.req0_ready, rst_n && !pend && w0 && !g);
                chk("req1_ready", bus.req1_ready, rst_n && !pend && w1 && g);
                chk("rsp0_valid", bus.rsp0_valid, resp_now && !owner);
                chk("rsp1_valid", bus.rsp1_valid, resp_now && owner);
                if (resp_now) begin
                    chk("rsp_data", bus.rsp_data, mexp[35:4]);
                    chk("rsp_status", bus.rsp_status, mexp[3:0]);
                end
                if (pend) chk("grant_id", bus.grant_id, owner);
                chk("fpu_op_a", bus.fpu_op_a, ma);
                chk("fpu_op_b", bus.fpu_op_b, mb);
                chk("fpu_rst_n", bus.fpu_rst_n, frst);
            end
            if (rst_n === 1'b0) begin
                known = 1; pend = 0; last = 1; frst = 0; ma = '0; mb = '0;
            end else if (known) begin
                if (!pend && (w0 || w1)) begin
                    owner = g; last = g; acc = cyc; pend = 1; frst = 0;
                    ma = g ? bus.req1_op_a : bus.req0_op_a;
                    mb = g ? bus.req1_op_b : bus.req0_op_b;
                    mexp = fpu_ref(ma, mb);
                    grant_log.push_back(g);
                end else begin
                    frst = 1;
                    rdy = owner ? (bus.rsp1_ready === 1'b1) : (bus.rsp0_ready === 1'b1);
                    if (resp_now && rdy) begin
                        pend = 0;
                        n_resp++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b,
                        output int unsigned acc);
        logic r;
        acc = 0;
        if (id) begin bus.req1_valid = 1; bus.req1_op_a = a; bus.req1_op_b = b; end
        else    begin bus.req0_valid = 1; bus.req0_op_a = a; bus.req0_op_b = b; end
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            r = id ? bus.req1_ready : bus.req0_ready;
            if (r === 1'b1) begin
                acc = cyc;
                tick();
                if (id) bus.req1_valid = 0; else bus.req0_valid = 0;
                return;
            end
            tick();
        end
        chk(id ? "send1_timeout" : "send0_timeout", r, 1);
    endtask

    task automatic recv(input bit id, output logic [31:0] d, output logic [3:0] s,
                        output int unsigned rc);
        logic v;
        d = '0; s = '0; rc = 0;
        if (id) bus.rsp1_ready = 1; else bus.rsp0_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            v = id ? bus.rsp1_valid : bus.rsp0_valid;
            if (v === 1'b1) begin
                d = bus.rsp_data; s = bus.rsp_status; rc = cyc;
                tick();
                if (id) bus.rsp1_ready = 0; else bus.rsp0_ready = 0;
                return;
            end
            tick();
        end
        chk(id ? "recv1_timeout" : "recv0_timeout", v, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                tick();
                return;
            end
        end
        chk("idle_timeout", bus.busy, 0);
    endtask

    function automatic logic [63:0] rand_pair();
        logic [31:0] a;
        if ($urandom_range(3) == 0) begin
            a = {1'($urandom_range(1)), 6'($urandom_range(63)), 25'h0};
            return {a, a};
        end
        return {32'($urandom), 32'($urandom)};
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : stim
        int unsigned acc, rc, acc0, acc1;
        logic [31:0] d, held;
        logic [3:0]  s;
        logic [63:0] p;
        bit          a0, a1;

        rst_n = 0;
        bus.req0_valid = 1; bus.req0_op_a = '0; bus.req0_op_b = '0; bus.rsp0_ready = 0;
        bus.req1_valid = 0; bus.req1_op_a = '0; bus.req1_op_b = '0; bus.rsp1_ready = 0;
        tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 0);
        chk("rst_fpu_rst_n", bus.fpu_rst_n, 0);
        chk("rst_fpu_op_a", bus.fpu_op_a, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_status", bus.rsp_status, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        bus.req0_valid = 0;
        rst_n = 1;
        tick();

        // Single request latency and value.
        send(0, 32'h3E00_0000, 32'h3E00_0000, acc);
        recv(0, d, s, rc);
        chk("t1_latency", rc - acc, W + 2);
        chk("t1_data", d, 32'h4000_0000);
        chk("t1_status", s, 4'b0001);

        // Contention after reset, then 4 continuous contended ops.
        rst_n = 0; tick(); rst_n = 1; tick();
        grant_log.delete();
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        fork
            send(0, 32'h1111_0001, 32'h2222_0002, acc0);
            send(1, 32'h3333_0003, 32'h4444_0004, acc1);
        join
        wait_idle();
        fork
            begin
                send(0, 32'h5555_0005, 32'h6666_0006, acc0);
                send(0, 32'h7777_0007, 32'h8888_0008, acc0);
            end
            begin
                send(1, 32'h9999_0009, 32'hAAAA_000A, acc1);
                send(1, 32'hBBBB_000B, 32'hCCCC_000C, acc1);
            end
        join
        wait_idle();
        chk("rr_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) chk($sformatf("rr_grant%0d", i), grant_log[i], i % 2);
        end
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;

        // Overflow.
        send(1, 32'h7E00_0000, 32'h7E00_0000, acc);
        recv(1, d, s, rc);
        chk("t4_data", d, 32'h0);
        chk("t4_status", s, 4'b0100);

        // Response back-pressure holds RESP and blocks new grants.
        send(1, 32'h0123_4567, 32'h89AB_CDEF, acc);
        held = '0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.rsp1_valid === 1'b1) begin
                held = bus.rsp_data;
                break;
            end
        end
        chk("t5_held_data", held, fpu_ref(32'h0123_4567, 32'h89AB_CDEF) >> 4);
        tick();
        bus.req0_valid = 1; bus.req0_op_a = 32'h3E00_0000; bus.req0_op_b = 32'h3E00_0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_rsp1_valid", bus.rsp1_valid, 1);
            chk("t5_data_stable", bus.rsp_data, held);
            chk("t5_req0_blocked", bus.req0_ready, 0);
            tick();
        end
        bus.rsp1_ready = 1;
        tick();
        bus.rsp1_ready = 0;
        chk("t5_idle_busy", bus.busy, 0);
        chk("t5_req0_ready", bus.req0_ready, 1);
        send(0, 32'h3E00_0000, 32'h3E00_0000, acc);
        recv(0, d, s, rc);
        chk("t5_req0_data", d, 32'h4000_0000);

        // Reset mid-WAIT aborts the transaction.
        send(0, 32'h0F0F_0F0F, 32'h1234_5678, acc);
        repeat (10) tick();
        rst_n = 0;
        tick();
        chk("t6_busy", bus.busy, 0);
        chk("t6_rsp0_valid", bus.rsp0_valid, 0);
        chk("t6_fpu_rst_n", bus.fpu_rst_n, 0);
        rst_n = 1;
        bus.rsp0_ready = 1;
        for (int i = 0; i < W + 10; i++) begin
            @(negedge clk);
            chk("t6_no_stale_rsp", bus.rsp0_valid, 0);
            tick();
        end
        bus.rsp0_ready = 0;
        send(0, 32'h3E00_0000, 32'h3E00_0000, acc);
        recv(0, d, s, rc);
        chk("t6_fresh_data", d, 32'h4000_0000);
        chk("t6_fresh_latency", rc - acc, W + 2);

        // Randomized traffic with occasional resets.
        n_resp = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            tick();
            if (bus.req0_valid) begin
                if (a0) begin
                    bus.req0_valid = ($urandom_range(2) != 0);
                    p = rand_pair(); bus.req0_op_a = p[63:32]; bus.req0_op_b = p[31:0];
                end else if ($urandom_range(15) == 0) bus.req0_valid = 0;
            end else begin
                bus.req0_valid = ($urandom_range(3) == 0);
                p = rand_pair(); bus.req0_op_a = p[63:32]; bus.req0_op_b = p[31:0];
            end
            if (bus.req1_valid) begin
                if (a1) begin
                    bus.req1_valid = ($urandom_range(2) != 0);
                    p = rand_pair(); bus.req1_op_a = p[63:32]; bus.req1_op_b = p[31:0];
                end else if ($urandom_range(15) == 0) bus.req1_valid = 0;
            end else begin
                bus.req1_valid = ($urandom_range(3) == 0);
                p = rand_pair(); bus.req1_op_a = p[63:32]; bus.req1_op_b = p[31:0];
            end
            bus.rsp0_ready = ($urandom_range(1) == 1);
            bus.rsp1_ready = ($urandom_range(1) == 1);
            rst_n = ($urandom_range(499) != 0);
        end
        rst_n = 1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        wait_idle();
        chk("rand_progress", n_resp > 10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
